// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared widths, select encoding and Tuse/Tnew constants
// Imported by the hazard controller and by the D-stage decoder.
package pipe_ctrl_pkg;

  localparam int AW = 5;
  localparam int TW = 2;

  localparam int FWD_RF = 0;

  localparam int TNEW_ALU      = 1;
  localparam int TNEW_LOAD     = 2;
  localparam int TUSE_BR       = 0;
  localparam int TUSE_ALU      = 1;
  localparam int TUSE_STORE_RT = 2;

  typedef struct packed {
    logic [AW-1:0] a3;
    logic [TW-1:0] tnew;
  } slot_t;

  function automatic logic [TW-1:0] tnew_dec(input logic [TW-1:0] t);
    return (t == '0) ? t : t - 1'b1;
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// rtl/pipe_hazard_ctrl_if.sv - D-stage decoder <-> hazard controller bundle
interface pipe_hazard_ctrl_if #(
  parameter int DEPTH = 3
);
  import pipe_ctrl_pkg::*;

  localparam int SW = $clog2(DEPTH + 1);

  logic          d_valid;
  logic [AW-1:0] d_rs;
  logic [AW-1:0] d_rt;
  logic          d_use_rs;
  logic          d_use_rt;
  logic [TW-1:0] d_tuse_rs;
  logic [TW-1:0] d_tuse_rt;
  logic [AW-1:0] d_a3;
  logic [TW-1:0] d_tnew;
  logic          d_md_start;
  logic          d_md_div;
  logic          d_md_use;
  logic          flush;
  logic          stall;
  logic [SW-1:0] fwd_rs_sel;
  logic [SW-1:0] fwd_rt_sel;
  logic          md_busy;

  modport master (
    output d_valid, d_rs, d_rt, d_use_rs, d_use_rt, d_tuse_rs, d_tuse_rt,
           d_a3, d_tnew, d_md_start, d_md_div, d_md_use, flush,
    input  stall, fwd_rs_sel, fwd_rt_sel, md_busy
  );

  modport slave (
    input  d_valid, d_rs, d_rt, d_use_rs, d_use_rt, d_tuse_rs, d_tuse_rt,
           d_a3, d_tnew, d_md_start, d_md_div, d_md_use, flush,
    output stall, fwd_rs_sel, fwd_rt_sel, md_busy
  );

endinterface

// File: rtl/md_busy_counter.sv
// rtl/md_busy_counter.sv - HI/LO unit busy counter
// Loaded when an MD op leaves E; counts down to zero and holds.
module md_busy_counter #(
  parameter int CW       = 4,
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10
) (
  input  logic clk,
  input  logic reset_n,
  input  logic load_i,
  input  logic div_i,
  output logic busy_o
);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = div_i ? CW'(DIV_LAT) : CW'(MULT_LAT);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign busy_o = (cnt_q != '0);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - Tuse/Tnew scoreboard, stall and forward-select generation
// Slot 0 is E; slots shift every cycle because E onward never stalls.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int DEPTH    = 3,
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10,
  parameter int CW       = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  pipe_hazard_ctrl_if.slave hz
);

  localparam int SW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic          stall;
    logic [SW-1:0] sel;
  } src_res_t;

  slot_t            slot_q [DEPTH];
  slot_t            slot_d [DEPTH];
  logic             md0_q, md0_d;
  logic             md0_div_q, md0_div_d;
  logic [DEPTH-1:0] hit_rs, hit_rt;
  src_res_t         res_rs, res_rt;
  logic             md_busy, stall_md, stall, issue;

  // Only the youngest matching slot counts, so a pending younger write hides older ready ones.
  function automatic src_res_t resolve(input logic [DEPTH-1:0] hit, input logic use_src,
                                       input logic [TW-1:0] tuse);
    src_res_t r;
    logic     found;
    r     = '{stall: 1'b0, sel: SW'(FWD_RF)};
    found = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      if (!found && hit[k]) begin
        found   = 1'b1;
        r.stall = use_src && (slot_q[k].tnew > tuse);
        if (slot_q[k].tnew == '0) r.sel = SW'(k + 1);
      end
    end
    return r;
  endfunction

  for (genvar k = 0; k < DEPTH; k++) begin : g_cmp
    assign hit_rs[k] = (hz.d_rs != '0) && (slot_q[k].a3 == hz.d_rs);
    assign hit_rt[k] = (hz.d_rt != '0) && (slot_q[k].a3 == hz.d_rt);
  end

  always_comb begin
    res_rs = resolve(hit_rs, hz.d_use_rs, hz.d_tuse_rs);
    res_rt = resolve(hit_rt, hz.d_use_rt, hz.d_tuse_rt);
  end

  // md0_q covers the E cycle of an MD op before the counter is loaded.
  assign stall_md  = hz.d_md_use && hz.d_valid && (md_busy || md0_q);
  assign stall     = hz.d_valid && (res_rs.stall || res_rt.stall || stall_md);
  assign issue     = hz.d_valid && !stall && !hz.flush;
  assign md0_d     = issue && hz.d_md_start;
  assign md0_div_d = md0_d && hz.d_md_div;

  assign slot_d[0] = issue ? slot_t'{a3: hz.d_a3, tnew: hz.d_tnew} : '0;
  for (genvar k = 1; k < DEPTH; k++) begin : g_adv
    assign slot_d[k] = slot_t'{a3: slot_q[k-1].a3, tnew: tnew_dec(slot_q[k-1].tnew)};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < DEPTH; k++) slot_q[k] <= '0;
      md0_q     <= 1'b0;
      md0_div_q <= 1'b0;
    end else begin
      for (int k = 0; k < DEPTH; k++) slot_q[k] <= slot_d[k];
      md0_q     <= md0_d;
      md0_div_q <= md0_div_d;
    end
  end

  md_busy_counter #(
    .CW       (CW),
    .MULT_LAT (MULT_LAT),
    .DIV_LAT  (DIV_LAT)
  ) u_md_busy (
    .clk     (clk),
    .reset_n (reset_n),
    .load_i  (md0_q),
    .div_i   (md0_div_q),
    .busy_o  (md_busy)
  );

  assign hz.stall      = stall;
  assign hz.fwd_rs_sel = res_rs.sel;
  assign hz.fwd_rt_sel = res_rt.sel;
  assign hz.md_busy    = md_busy;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - directed scoreboard bench for pipe_hazard_ctrl (DEPTH=3 and DEPTH=5)
module tb_pipe_hazard_ctrl;
  import pipe_ctrl_pkg::*;

  typedef struct packed {
    logic       inst;
    logic       stall;
    logic [2:0] rs;
    logic [2:0] rt;
    logic       busy;
  } exp_t;

  logic  clk = 1'b0;
  logic  reset_n = 1'b1;
  int    n_cmp = 0;
  int    n_bad = 0;
  exp_t  exp_q[$];
  string tag_q[$];

  pipe_hazard_ctrl_if #(.DEPTH(3)) h3();
  pipe_hazard_ctrl_if #(.DEPTH(5)) h5();

  pipe_hazard_ctrl #(.DEPTH(3)) u_d3 (.clk(clk), .reset_n(reset_n), .hz(h3.slave));
  pipe_hazard_ctrl #(.DEPTH(5)) u_d5 (.clk(clk), .reset_n(reset_n), .hz(h5.slave));

  always #5 clk = ~clk;

  task automatic drv(input int v, input int a3, input int tnew, input int rs, input int urs,
                     input int trs, input int rt, input int urt, input int trt,
                     input int mds, input int mdd, input int mdu, input int fl);
    h3.d_valid = 1'(v);     h5.d_valid = 1'(v);
    h3.d_a3 = 5'(a3);       h5.d_a3 = 5'(a3);
    h3.d_tnew = 2'(tnew);   h5.d_tnew = 2'(tnew);
    h3.d_rs = 5'(rs);       h5.d_rs = 5'(rs);
    h3.d_use_rs = 1'(urs);  h5.d_use_rs = 1'(urs);
    h3.d_tuse_rs = 2'(trs); h5.d_tuse_rs = 2'(trs);
    h3.d_rt = 5'(rt);       h5.d_rt = 5'(rt);
    h3.d_use_rt = 1'(urt);  h5.d_use_rt = 1'(urt);
    h3.d_tuse_rt = 2'(trt); h5.d_tuse_rt = 2'(trt);
    h3.d_md_start = 1'(mds); h5.d_md_start = 1'(mds);
    h3.d_md_div = 1'(mdd);  h5.d_md_div = 1'(mdd);
    h3.d_md_use = 1'(mdu);  h5.d_md_use = 1'(mdu);
    h3.flush = 1'(fl);      h5.flush = 1'(fl);
  endtask

  task automatic bub();
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    bub();
    repeat (5) tick();
  endtask

  task automatic want3(input string t, input int st, input int rs, input int rt, input int b);
    exp_q.push_back('{inst: 1'b0, stall: 1'(st), rs: 3'(rs), rt: 3'(rt), busy: 1'(b)});
    tag_q.push_back(t);
  endtask

  task automatic want5(input string t, input int st, input int rs, input int rt, input int b);
    exp_q.push_back('{inst: 1'b1, stall: 1'(st), rs: 3'(rs), rt: 3'(rt), busy: 1'(b)});
    tag_q.push_back(t);
  endtask

  task automatic chk();
    exp_t  e, o;
    string t;
    #1;
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      if (e.inst)
        o = {1'b1, h5.stall, h5.fwd_rs_sel, h5.fwd_rt_sel, h5.md_busy};
      else
        o = {1'b0, h3.stall, 1'b0, h3.fwd_rs_sel, 1'b0, h3.fwd_rt_sel, h3.md_busy};
      n_cmp++;
      assert (o === e) else begin
        n_bad++;
        $error("FAIL %s observed=%b required=%b (inst/stall/rs/rt/busy)", t, o, e);
      end
    end
  endtask

  task automatic cmp_int(input string t, input int obs, input int req);
    n_cmp++;
    assert (obs == req) else begin
      n_bad++;
      $error("FAIL %s observed=%0d required=%0d", t, obs, req);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bub();
    #1 reset_n = 1'b0;
    want3("reset_d3", 0, 0, 0, 0);
    want5("reset_d5", 0, 0, 0, 0);
    chk();
    @(negedge clk) reset_n = 1'b1;
    tick();

    // lw $1 then add $3,$1,$2
    drv(1, 1, TNEW_LOAD, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    want3("t1_lw_at_d", 0, 0, 0, 0); chk();
    tick();
    drv(1, 3, TNEW_ALU, 1, 1, TUSE_ALU, 2, 1, TUSE_ALU, 0, 0, 0, 0);
    want3("t1_stall", 1, 0, 0, 0); chk();
    tick();
    want3("t1_release", 0, 0, 0, 0); chk();
    tick();

    // lw $2 then store reading rt (no stall), then branch reading rt (stall)
    drain();
    drv(1, 2, TNEW_LOAD, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    drv(1, 0, 0, 0, 0, 0, 2, 1, TUSE_STORE_RT, 0, 0, 0, 0);
    want3("rt_store_ok", 0, 0, 0, 0); chk();
    drv(1, 0, 0, 0, 0, 0, 2, 1, TUSE_BR, 0, 0, 0, 0);
    want3("rt_branch_stall", 1, 0, 0, 0); chk();

    // add $1, nop, beq $1
    drain();
    drv(1, 1, TNEW_ALU, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    drv(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    drv(1, 0, 0, 1, 1, TUSE_BR, 0, 1, TUSE_BR, 0, 0, 0, 0);
    want3("t2_fwd_slot1", 0, 2, 0, 0); chk();
    tick();

    // ori $1, lw $1, beq $1
    drain();
    drv(1, 1, TNEW_ALU, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    drv(1, 1, TNEW_LOAD, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    drv(1, 0, 0, 1, 1, TUSE_BR, 0, 0, 0, 0, 0, 0, 0);
    want3("t3_stall_a", 1, 0, 0, 0); chk();
    tick();
    want3("t3_stall_b", 1, 0, 0, 0); chk();
    tick();
    want3("t3_fwd_slot2", 0, 3, 0, 0); chk();
    tick();

    // $0 destination is never a hazard
    drain();
    drv(1, 0, TNEW_LOAD, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    drv(1, 0, 0, 0, 1, TUSE_BR, 0, 1, TUSE_BR, 0, 0, 0, 0);
    want3("zero_reg", 0, 0, 0, 0); chk();

    // div then mflo
    drain();
    drv(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0);
    want3("t4_div_at_d", 0, 0, 0, 0); chk();
    tick();
    drv(1, 3, TNEW_ALU, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    #1;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (!h3.stall) break;
      n++;
      tick();
    end
    cmp_int("t4_stall_cycles", n, 11);
    want3("t4_mflo_issue", 0, 0, 0, 0); chk();
    tick();

    // flush with a valid mult at D
    drain();
    drv(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1);
    want3("t5_flush_at_d", 0, 0, 0, 0); chk();
    tick();
    drv(1, 3, TNEW_ALU, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    want3("t5_no_md_after", 0, 0, 0, 0); chk();
    tick();
    want3("t5_still_idle", 0, 0, 0, 0); chk();

    // async reset while divide busy=7
    drain();
    drv(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0);
    tick();
    drv(1, 3, TNEW_ALU, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    repeat (4) tick();
    want3("t6_busy7", 1, 0, 0, 1); chk();
    #2 reset_n = 1'b0;
    #1;
    want3("t6_async_clear", 0, 0, 0, 0); chk();
    @(negedge clk) reset_n = 1'b1;
    tick();
    want3("t6_after_release", 0, 0, 0, 0); chk();

    // last-slot drop-out, DEPTH=3 vs DEPTH=5
    drain();
    drv(1, 5, TNEW_ALU, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    bub();
    tick();
    tick();
    drv(1, 0, 0, 5, 1, TUSE_BR, 5, 0, 0, 0, 0, 0, 0);
    want3("d3_slot2", 0, 3, 3, 0);
    want5("d5_slot2", 0, 3, 3, 0);
    chk();
    tick();
    want3("d3_dropout", 0, 0, 0, 0);
    want5("d5_slot3", 0, 4, 4, 0);
    chk();
    tick();
    want3("d3_gone", 0, 0, 0, 0);
    want5("d5_slot4", 0, 5, 5, 0);
    chk();
    tick();
    want5("d5_dropout", 0, 0, 0, 0);
    chk();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
